// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_pkg
//  Brief    : Shared float format constants, accumulator FSM states and
//             the unpacked-float type used by the FP reduction datapath.
//  Revision : 1.0  initial release
// ============================================================================
package fp_pkg;

    localparam int FP_WIDTH  = 32;
    localparam int EXP_WIDTH = 8;
    localparam int MAN_WIDTH = 23;
    localparam int GRD_WIDTH = 3;
    localparam int BIAS      = 2**(EXP_WIDTH-1) - 1;
    localparam int EXP_MAX   = 2**EXP_WIDTH - 1;

    // hidden bit + stored mantissa + guard bits
    localparam int MANT_W    = MAN_WIDTH + GRD_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        OUT   = 3'd4
    } state_t;

    typedef struct packed {
        logic                 sign;
        logic [EXP_WIDTH-1:0] exp;
        logic [MANT_W-1:0]    mant;
    } ufloat_t;

    // Split a packed float; a zero exponent flushes the value to a signed zero.
    function automatic ufloat_t unpack_fp(input logic [FP_WIDTH-1:0] x);
        ufloat_t u;
        u.sign = x[FP_WIDTH-1];
        u.exp  = x[FP_WIDTH-2 -: EXP_WIDTH];
        u.mant = (u.exp == '0) ? '0
                               : {1'b1, x[MAN_WIDTH-1:0], {GRD_WIDTH{1'b0}}};
        return u;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_acc_seq_lzc.sv
`default_nettype none
// ============================================================================
//  Module   : lzc
//  Brief    : Parameterised leading-zero counter. An all-zero input
//             reports WIDTH.
//  Revision : 1.0  initial release
// ============================================================================
module lzc #(
    parameter int WIDTH = 28,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);

    // Scan upward so the highest set bit is the last to write the count.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_acc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fp_acc_seq
//  Brief    : Sequential floating-point accumulator. Absorbs one product
//             every four cycles over valid/ready and presents the running
//             sum once the element flagged last has been added.
//             Truncation rounding, denormals flushed to zero, Inf/NaN
//             inputs treated as large finite values.
//  Revision : 1.0  initial release
// ============================================================================
module fp_acc_seq #(
    parameter int FP_WIDTH  = 32,
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int GRD_WIDTH = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [FP_WIDTH-1:0] in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [FP_WIDTH-1:0] out_data
);

    import fp_pkg::*;

    // Widths below must agree with the format constants in fp_pkg, which
    // size the unpacked-float struct.
    localparam int MW = MAN_WIDTH + GRD_WIDTH + 1;  // hidden + man + guard
    localparam int SW = MW + 1;                     // plus add carry
    localparam int CW = $clog2(SW + 1);             // leading-zero count
    localparam int EW = EXP_WIDTH + 2;              // signed exponent work

    localparam logic signed [EW-1:0] EXP_SAT = EW'(EXP_MAX);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [FP_WIDTH-1:0]   r_acc;
    logic [FP_WIDTH-1:0]   r_op;
    logic                  r_last;
    ufloat_t               r_a;
    logic                  r_b_sign;
    logic [MW-1:0]         r_b_mant;
    logic [SW-1:0]         r_sum;
    logic                  r_in_ready;
    logic                  r_out_valid;

    // ------------------------------------------------------------------
    // ALIGN: order operands by magnitude and shift the smaller one down
    // ------------------------------------------------------------------
    ufloat_t               w_x;
    ufloat_t               w_y;
    ufloat_t               w_big;
    ufloat_t               w_small;
    logic                  w_swap;
    logic [EXP_WIDTH-1:0]  w_diff;
    logic [MW-1:0]         w_small_shifted;

    // Pick the larger magnitude as A; bits shifted out of B are simply lost.
    always_comb begin
        w_x    = unpack_fp(r_acc);
        w_y    = unpack_fp(r_op);
        w_swap = (w_y.exp > w_x.exp) ||
                 ((w_y.exp == w_x.exp) && (w_y.mant > w_x.mant));
        w_big   = w_swap ? w_y : w_x;
        w_small = w_swap ? w_x : w_y;
        w_diff  = w_big.exp - w_small.exp;
        if (int'(w_diff) >= MW) begin
            w_small_shifted = '0;
        end else begin
            w_small_shifted = w_small.mant >> w_diff;
        end
    end

    // ------------------------------------------------------------------
    // ADD: magnitude add/subtract; A >= B so subtraction never wraps
    // ------------------------------------------------------------------
    logic [SW-1:0]         w_sum;

    // Like signs add with a carry bit, unlike signs subtract B from A.
    always_comb begin
        if (r_a.sign == r_b_sign) begin
            w_sum = {1'b0, r_a.mant} + {1'b0, r_b_mant};
        end else begin
            w_sum = {1'b0, r_a.mant} - {1'b0, r_b_mant};
        end
    end

    // ------------------------------------------------------------------
    // NORM: renormalise, detect zero/underflow/overflow, truncate guards
    // ------------------------------------------------------------------
    logic [CW-1:0]          w_lz;
    logic [SW-1:0]          w_shifted;
    logic [MW-1:0]          w_mant_n;
    logic signed [EW-1:0]   w_exp_a;
    logic signed [EW-1:0]   w_lz_s;
    logic signed [EW-1:0]   w_exp_n;
    logic [FP_WIDTH-1:0]    w_result;
    logic                   w_unused_bits;

    lzc #(
        .WIDTH (SW),
        .CNT_W (CW)
    ) u_lzc (
        .data  (r_sum),
        .count (w_lz)
    );

    // The count spans the carry bit, so a no-carry sum needs count-1 of
    // left shift to bring its leading one up to the hidden-bit position.
    always_comb begin
        w_exp_a   = $signed({2'b00, r_a.exp});
        w_lz_s    = $signed(EW'(w_lz));
        w_shifted = r_sum << (w_lz - CW'(1));
        if (r_sum[SW-1]) begin
            w_mant_n = r_sum[SW-1:1];
            w_exp_n  = w_exp_a + EW'(1);
        end else begin
            w_mant_n = w_shifted[MW-1:0];
            w_exp_n  = w_exp_a - w_lz_s + EW'(1);
        end

        if ((r_sum == '0) || (w_exp_n <= EW'(0))) begin
            w_result = '0;
        end else if (w_exp_n >= EXP_SAT) begin
            w_result = {r_a.sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
        end else begin
            w_result = {r_a.sign, w_exp_n[EXP_WIDTH-1:0],
                        w_mant_n[MW-2 -: MAN_WIDTH]};
        end
    end

    // Hidden bit, guard bits and high exponent bits are dropped on packing.
    assign w_unused_bits = ^{w_mant_n[MW-1], w_mant_n[GRD_WIDTH-1:0],
                             w_exp_n[EW-1:EXP_WIDTH], w_shifted[SW-1:MW]};

    // ------------------------------------------------------------------
    // Control FSM with registered handshake outputs
    // ------------------------------------------------------------------

    // One element walks IDLE->ALIGN->ADD->NORM; the last one parks in OUT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_op        <= '0;
            r_last      <= 1'b0;
            r_a         <= '0;
            r_b_sign    <= 1'b0;
            r_b_mant    <= '0;
            r_sum       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_op       <= in_data;
                        r_last     <= in_last;
                        r_in_ready <= 1'b0;
                        r_state    <= ALIGN;
                    end
                end
                ALIGN: begin
                    r_a      <= w_big;
                    r_b_sign <= w_small.sign;
                    r_b_mant <= w_small_shifted;
                    r_state  <= ADD;
                end
                ADD: begin
                    r_sum   <= w_sum;
                    r_state <= NORM;
                end
                NORM: begin
                    r_acc <= w_result;
                    if (r_last) begin
                        r_out_valid <= 1'b1;
                        r_state     <= OUT;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_acc       <= '0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    // Outputs are forced quiet for as long as reset is held.
    assign in_ready  = r_in_ready  & rst_n;
    assign out_valid = r_out_valid & rst_n;
    assign out_data  = rst_n ? r_acc : '0;

endmodule
`default_nettype wire

// File: tb/tb_fp_acc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_acc_seq
//  Brief    : Self-checking bench for fp_acc_seq: directed sums, handshake
//             hold, mid-operation reset, throughput and random sums
//             checked against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_acc_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int checks = 0;
    int errors = 0;

    fp_acc_seq #(
        .FP_WIDTH  (32),
        .EXP_WIDTH (8),
        .MAN_WIDTH (23),
        .GRD_WIDTH (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Reference model: value = sig * 2^(exp-bias-26), sig with 3 guard bits
    // ------------------------------------------------------------------
    function automatic logic [31:0] ref_add(input logic [31:0] p, input logic [31:0] q);
        longint ma, mb, s, t, tl;
        int     ea, eb, e, msb, ti;
        logic   sa, sb, tb;
        ea = int'(p[30:23]);
        eb = int'(q[30:23]);
        sa = p[31];
        sb = q[31];
        ma = (ea == 0) ? 0 : (longint'({1'b1, p[22:0]}) << 3);
        mb = (eb == 0) ? 0 : (longint'({1'b1, q[22:0]}) << 3);
        if (eb > ea || (eb == ea && mb > ma)) begin
            ti = ea; ea = eb; eb = ti;
            tl = ma; ma = mb; mb = tl;
            tb = sa; sa = sb; sb = tb;
        end
        if (ea - eb >= 27) mb = 0;
        else               mb = mb >> (ea - eb);
        s = (sa == sb) ? (ma + mb) : (ma - mb);
        if (s == 0) return 32'h0;
        msb = 0;
        t   = s;
        while (t > 1) begin
            t = t >> 1;
            msb++;
        end
        e = ea + msb - 26;
        if (e <= 0)   return 32'h0;
        if (e >= 255) return {sa, 8'hFF, 23'h0};
        if (msb >= 26) t = s >> (msb - 26);
        else           t = s << (26 - msb);
        return {sa, e[7:0], t[25:3]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        int sel;
        sel = int'($urandom_range(0, 15));
        if (sel == 0)      e = 8'h00;
        else if (sel == 1) e = 8'($urandom_range(250, 255));
        else               e = 8'($urandom_range(118, 136));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready never rose for %h", d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'($urandom);
    endtask

    // Cycle 1 is the cycle that follows the accept edge of the last element.
    task automatic get_result(input int delay, output logic [31:0] d, output int lat);
        lat = 0;
        d   = 'x;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) begin
            checks++; errors++;
            $display("FAIL result_timeout: out_valid never rose");
        end else begin
            repeat (delay) @(negedge clk);
            d = out_data;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 00000000", out_data); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_directed();
        logic [31:0] a_op [6];
        logic [31:0] b_op [6];
        logic [31:0] want [6];
        int          n_op [6];
        logic [31:0] got;
        int          lat;
        a_op[0] = 32'h3F800000; b_op[0] = 32'h40000000; n_op[0] = 2; want[0] = 32'h40400000;
        a_op[1] = 32'h3FC00000; b_op[1] = 32'hBFC00000; n_op[1] = 2; want[1] = 32'h00000000;
        a_op[2] = 32'h4B800000; b_op[2] = 32'h3F800000; n_op[2] = 2; want[2] = 32'h4B800000;
        a_op[3] = 32'h7F7FFFFF; b_op[3] = 32'h7F7FFFFF; n_op[3] = 2; want[3] = 32'h7F800000;
        a_op[4] = 32'h00000001; b_op[4] = 32'h0;        n_op[4] = 1; want[4] = 32'h00000000;
        a_op[5] = 32'hC0A00000; b_op[5] = 32'h0;        n_op[5] = 1; want[5] = 32'hC0A00000;
        for (int k = 0; k < 6; k++) begin
            send(a_op[k], n_op[k] == 1);
            if (n_op[k] == 2) send(b_op[k], 1'b1);
            get_result(0, got, lat);
            checks++;
            if (got !== want[k]) begin
                errors++;
                $display("FAIL directed_%0d: got %h want %h", k, got, want[k]);
            end
            if (k == 0) begin
                checks++;
                if (lat !== 4) begin
                    errors++;
                    $display("FAIL latency: out_valid in cycle %0d want 4", lat);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops [3];
        int          acc_cyc [3];
        int          k, cyc, lat;
        logic [31:0] got;
        ops[0] = 32'h3F800000; ops[1] = 32'h3F800000; ops[2] = 32'h40000000;
        k   = 0;
        cyc = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = ops[0];
        in_last  = 1'b0;
        while (k < 3 && cyc < 40) begin
            if (in_ready) begin
                acc_cyc[k] = cyc;
                k++;
            end
            @(posedge clk);
            #1;
            if (k < 3) begin
                in_data = ops[k];
                in_last = (k == 2);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (k !== 3) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d want 3", k);
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (acc_cyc[i] - acc_cyc[i-1] !== 4) begin
                    errors++;
                    $display("FAIL b2b_spacing_%0d: got %0d want 4", i, acc_cyc[i] - acc_cyc[i-1]);
                end
            end
        end
        get_result(0, got, lat);
        checks++;
        if (got !== 32'h40800000) begin errors++; $display("FAIL b2b_sum: got %h want 40800000", got); end
    endtask

    task automatic test_hold();
        logic [31:0] got;
        int          lat;
        lat = 0;
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b1);
        for (int c = 1; c <= 60 && lat == 0; c++) begin
            @(negedge clk);
            if (out_valid) lat = c;
        end
        checks++;
        if (lat == 0) begin errors++; $display("FAIL hold_wait: out_valid never rose"); end
        // junk offered while the sum is pending must be ignored
        in_valid = 1'b1;
        in_data  = 32'h44444444;
        in_last  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid_%0d: got %b want 1", c, out_valid); end
            checks++;
            if (out_data !== 32'h40400000) begin errors++; $display("FAIL hold_data_%0d: got %h want 40400000", c, out_data); end
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready_%0d: got %b want 0", c, in_ready); end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid: got %b want 0", out_valid); end
        send(32'h3F800000, 1'b1);
        get_result(1, got, lat);
        checks++;
        if (got !== 32'h3F800000) begin errors++; $display("FAIL cleared_acc: got %h want 3F800000", got); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        int          lat;
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b1);
        @(negedge clk);            // ALIGN
        @(negedge clk);            // ADD
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready_low: got %b want 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid_low: got %b want 0", out_valid); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        checks++;
        if (out_data !== 32'h0) begin errors++; $display("FAIL midrst_out_data: got %h want 00000000", out_data); end
        send(32'h40000000, 1'b1);
        get_result(0, got, lat);
        checks++;
        if (got !== 32'h40000000) begin errors++; $display("FAIL midrst_sum: got %h want 40000000", got); end
    endtask

    task automatic test_random();
        logic [31:0] acc, op, got;
        int          len, lat;
        for (int s = 0; s < 40; s++) begin
            acc = 32'h0;
            len = int'($urandom_range(1, 4));
            for (int i = 0; i < len; i++) begin
                op  = rand_fp();
                acc = ref_add(acc, op);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send(op, i == len - 1);
            end
            get_result(int'($urandom_range(0, 3)), got, lat);
            checks++;
            if (got !== acc) begin
                errors++;
                $display("FAIL random_%0d: got %h want %h (len %0d)", s, got, acc, len);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
